// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT front-end: window feeder state encoding
// and the width of pixel coordinates.
package sift_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } feederState_e;

endpackage

// File: rtl/sift_line_buf.sv
// One raster line of pixel storage: combinational read, registered write.
// Contents are not reset; every entry is written before it is consumed.
module sift_line_buf #(
    parameter int DEPTH = 640,
    parameter int DW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          iclk,
    input  logic          iWe,
    input  logic [AW-1:0] iAddr,
    input  logic [DW-1:0] iData,
    output logic [DW-1:0] oData
);

    logic [DW-1:0] mem_r [DEPTH];

    assign oData = mem_r[iAddr];

    // Synchronous write port; the read above returns the pre-write value.
    always_ff @(posedge iclk) begin
        if (iWe) begin
            mem_r[iAddr] <= iData;
        end
    end

endmodule

// File: rtl/dog_window_feeder.sv
// Builds a 3x3 sliding window over a raster DoG stream and emits it, with the
// centre coordinate, for every non-border centre of the frame.
module dog_window_feeder
    import sift_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               iValid,
    input  logic               iSof,
    input  logic [DW-1:0]      iData,
    output logic               oValid,
    output logic [DW-1:0]      oT0,
    output logic [DW-1:0]      oT1,
    output logic [DW-1:0]      oT2,
    output logic [DW-1:0]      oM0,
    output logic [DW-1:0]      oC,
    output logic [DW-1:0]      oM2,
    output logic [DW-1:0]      oB0,
    output logic [DW-1:0]      oB1,
    output logic [DW-1:0]      oB2,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oEof
);

    localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(IMG_H - 1);

    feederState_e       state_r, nextState_s;
    logic [COORD_W-1:0] colCnt_r, rowCnt_r, nextCol_s, nextRow_s;
    logic [COORD_W-1:0] curX_s, curY_s;
    logic               accept_s, lastPix_s, emit_s;
    logic [LB_AW-1:0]   lbAddr_s;
    logic [DW-1:0]      lb1Rd_s, lb2Rd_s;
    // Two most recent columns of each window row, oldest first.
    logic [DW-1:0]      winT0_r, winT1_r, winM0_r, winM1_r, winB0_r, winB1_r;

    // A start-of-frame pixel always lands at (0,0), in either state.
    assign curX_s   = iSof ? {COORD_W{1'b0}} : colCnt_r;
    assign curY_s   = iSof ? {COORD_W{1'b0}} : rowCnt_r;
    assign lbAddr_s = curX_s[LB_AW-1:0];
    assign emit_s   = accept_s && (curX_s >= COORD_W'(2)) && (curY_s >= COORD_W'(2));

    sift_line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(LB_AW)) uLineBuf1 (
        .iclk  (iclk),
        .iWe   (accept_s),
        .iAddr (lbAddr_s),
        .iData (iData),
        .oData (lb1Rd_s)
    );

    sift_line_buf #(.DEPTH(IMG_W), .DW(DW), .AW(LB_AW)) uLineBuf2 (
        .iclk  (iclk),
        .iWe   (accept_s),
        .iAddr (lbAddr_s),
        .iData (lb1Rd_s),
        .oData (lb2Rd_s)
    );

    // Acceptance, raster position advance and frame-end detection.
    always_comb begin
        accept_s    = 1'b0;
        lastPix_s   = 1'b0;
        nextState_s = state_r;
        nextCol_s   = colCnt_r;
        nextRow_s   = rowCnt_r;
        case (state_r)
            IDLE:    accept_s = iValid && iSof;
            ACTIVE:  accept_s = iValid;
            default: accept_s = 1'b0;
        endcase
        if (accept_s) begin
            if (curX_s == LAST_X) begin
                nextCol_s = {COORD_W{1'b0}};
                if (curY_s == LAST_Y) begin
                    nextRow_s   = {COORD_W{1'b0}};
                    nextState_s = IDLE;
                    lastPix_s   = 1'b1;
                end else begin
                    nextRow_s   = curY_s + 11'd1;
                    nextState_s = ACTIVE;
                end
            end else begin
                nextCol_s   = curX_s + 11'd1;
                nextRow_s   = curY_s;
                nextState_s = ACTIVE;
            end
        end else begin
            nextState_s = state_r;
        end
    end

    // State and raster counters.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r  <= IDLE;
            colCnt_r <= {COORD_W{1'b0}};
            rowCnt_r <= {COORD_W{1'b0}};
        end else begin
            state_r  <= nextState_s;
            colCnt_r <= nextCol_s;
            rowCnt_r <= nextRow_s;
        end
    end

    // Window shift on every accepted pixel; outputs load only for interior centres.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            winT0_r <= '0; winT1_r <= '0;
            winM0_r <= '0; winM1_r <= '0;
            winB0_r <= '0; winB1_r <= '0;
            oT0 <= '0; oT1 <= '0; oT2 <= '0;
            oM0 <= '0; oC  <= '0; oM2 <= '0;
            oB0 <= '0; oB1 <= '0; oB2 <= '0;
            oX     <= {COORD_W{1'b0}};
            oY     <= {COORD_W{1'b0}};
            oValid <= 1'b0;
            oEof   <= 1'b0;
        end else begin
            oValid <= emit_s;
            oEof   <= lastPix_s;
            if (accept_s) begin
                winT0_r <= winT1_r; winT1_r <= lb2Rd_s;
                winM0_r <= winM1_r; winM1_r <= lb1Rd_s;
                winB0_r <= winB1_r; winB1_r <= iData;
            end
            if (emit_s) begin
                oT0 <= winT0_r; oT1 <= winT1_r; oT2 <= lb2Rd_s;
                oM0 <= winM0_r; oC  <= winM1_r; oM2 <= lb1Rd_s;
                oB0 <= winB0_r; oB1 <= winB1_r; oB2 <= iData;
                oX  <= curX_s - 11'd1;
                oY  <= curY_s - 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_dog_window_feeder.sv
// Directed bench for dog_window_feeder on an 8x6 frame fed with a ramp.
module tb_dog_window_feeder;

    localparam int W = 8;
    localparam int H = 6;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        iValid = 1'b0;
    logic        iSof = 1'b0;
    logic [7:0]  iData = 8'd0;
    logic        oValid, oEof;
    logic [7:0]  oT0, oT1, oT2, oM0, oC, oM2, oB0, oB1, oB2;
    logic [10:0] oX, oY;

    int checks = 0;
    int errors = 0;
    int validCnt = 0;
    int eofCnt = 0;

    dog_window_feeder #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iSof(iSof), .iData(iData),
        .oValid(oValid), .oT0(oT0), .oT1(oT1), .oT2(oT2), .oM0(oM0), .oC(oC),
        .oM2(oM2), .oB0(oB0), .oB1(oB1), .oB2(oB2), .oX(oX), .oY(oY), .oEof(oEof)
    );

    always #5 iclk = ~iclk;

    always @(negedge iclk) begin
        if (oValid === 1'b1) validCnt++;
        if (oEof === 1'b1) eofCnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one pixel with iValid=1 and sample the registered result after the edge.
    task automatic pix(input logic sof, input logic [7:0] d);
        @(negedge iclk);
        iValid = 1'b1; iSof = sof; iData = d;
        @(posedge iclk); #1;
    endtask

    task automatic gap();
        @(negedge iclk);
        iValid = 1'b0; iSof = 1'b0; iData = 8'hA5;
        @(posedge iclk); #1;
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_valid"}, oValid, 1'b0);
        chk({tag, "_eof"}, oEof, 1'b0);
        chk({tag, "_xy"}, {oX, oY}, 32'd0);
        chk({tag, "_top"}, {oT0, oT1, oT2}, 32'd0);
        chk({tag, "_mid"}, {oM0, oC, oM2}, 32'd0);
        chk({tag, "_bot"}, {oB0, oB1, oB2}, 32'd0);
    endtask

    // Full ramp frame; with gaps an idle cycle follows every pixel.
    task automatic frame(input string tag, input bit gaps);
        int v0, e0, x, y;
        logic [7:0]  heldC;
        logic [10:0] heldX;
        v0 = validCnt; e0 = eofCnt;
        for (int i = 0; i < W * H; i++) begin
            x = i % W; y = i / W;
            pix(i == 0, 8'(i));
            if (x >= 2 && y >= 2) begin
                chk({tag, "_valid"}, oValid, 1'b1);
                chk({tag, "_x"}, oX, x - 1);
                chk({tag, "_y"}, oY, y - 1);
                chk({tag, "_c"}, oC, (y - 1) * W + x - 1);
                chk({tag, "_t0"}, oT0, (y - 2) * W + x - 2);
                chk({tag, "_b2"}, oB2, y * W + x);
            end else begin
                chk({tag, "_novalid"}, oValid, 1'b0);
            end
            if (i == 18) begin
                chk({tag, "_first_top"}, {oT0, oT1, oT2}, {8'd0, 8'd1, 8'd2});
                chk({tag, "_first_mid"}, {oM0, oC, oM2}, {8'd8, 8'd9, 8'd10});
                chk({tag, "_first_bot"}, {oB0, oB1, oB2}, {8'd16, 8'd17, 8'd18});
            end
            chk({tag, "_eof"}, oEof, (i == W * H - 1) ? 1'b1 : 1'b0);
            if (gaps) begin
                heldC = oC; heldX = oX;
                gap();
                chk({tag, "_gap_valid"}, oValid, 1'b0);
                chk({tag, "_gap_hold"}, {oC, oX}, {heldC, heldX});
            end
        end
        gap();
        chk({tag, "_eof_end"}, oEof, 1'b0);
        chk({tag, "_count"}, validCnt - v0, 24);
        chk({tag, "_eofcnt"}, eofCnt - e0, 1);
    endtask

    initial begin
        int v0, e0;
        #12;
        chkZero("reset");
        @(negedge iclk); irst_n = 1'b1;

        // Pixels before any start-of-frame are dropped.
        v0 = validCnt;
        for (int i = 0; i < 30; i++) pix(1'b0, 8'(i));
        gap();
        chk("drop_count", validCnt - v0, 0);
        chkZero("drop");

        frame("ramp", 1'b0);
        frame("gaps", 1'b1);

        // Restart at pixel 20: two interior centres before it, then a full frame.
        v0 = validCnt; e0 = eofCnt;
        for (int i = 0; i < 20; i++) pix(i == 0, 8'(i));
        chk("pre_restart_x", oX, 2);
        pix(1'b1, 8'd0);
        chk("restart_valid", oValid, 1'b0);
        chk("restart_eof", oEof, 1'b0);
        for (int k = 1; k < W * H; k++) begin
            pix(1'b0, 8'(k));
            if (k == 17) chk("restart_pre_first", oValid, 1'b0);
            if (k == 18) begin
                chk("restart_first_valid", oValid, 1'b1);
                chk("restart_first_xy", {oX, oY}, {5'd0, 11'd1, 11'd1});
                chk("restart_first_c", oC, 9);
            end
        end
        gap();
        chk("restart_count", validCnt - v0, 26);
        chk("restart_eofcnt", eofCnt - e0, 1);

        // Asynchronous reset in the middle of a frame.
        e0 = eofCnt;
        for (int i = 0; i < 31; i++) pix(i == 0, 8'(i));
        chk("prereset_valid", oValid, 1'b1);
        chk("prereset_c", oC, 21);
        @(negedge iclk); iValid = 1'b0; #2 irst_n = 1'b0; #1;
        chkZero("midreset");
        @(negedge iclk); irst_n = 1'b1;
        v0 = validCnt;
        for (int i = 31; i < 48; i++) pix(1'b0, 8'(i));
        gap();
        chk("postreset_count", validCnt - v0, 0);
        chk("postreset_eofcnt", eofCnt - e0, 0);
        chkZero("postreset");
        frame("after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
